srl_fifo_rd_ctrl: RTL and testbench



---
 rtl/srl_fifo_rd_ctrl.sv | 142 ++++++++++++++
 tb/tb_srl_fifo_rd_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// srl_fifo_rd_ctrl
//
// Shift-register FIFO carrying data/start tokens between dataflow processes.
// Owns the SRL storage, the occupancy counter that forms the SRL read
// address, and both handshake ends.
//
// Optional feature macro: SRL_FIFO_OUT_REG_EN
//   defined   : registered output stage after the SRL (capacity DEPTH+1,
//               push-to-visible latency 2 cycles, if_dout from a register)
//   undefined : combinational SRL read path (capacity DEPTH, latency 1)
//
// Handshake (both ends): a push happens on a rising edge where
// if_write & if_write_ce & if_full_n; a pop happens where
// if_read & if_read_ce & if_empty_n. Requests while the flag is low are
// ignored and change nothing.
//
// Ports:
//   clk               in   clock, all state on rising edge
//   reset             in   synchronous active-high reset
//   if_write_ce       in   producer clock enable
//   if_write          in   producer push request
//   if_din            in   push data [DATA_WIDTH]
//   if_full_n         out  space available (registered)
//   if_read_ce        in   consumer clock enable
//   if_read           in   consumer pop request
//   if_dout           out  head-of-FIFO data [DATA_WIDTH]
//   if_empty_n        out  head data valid (registered)
//   if_num_data_valid out  current occupancy [ADDR_WIDTH+1]
//   if_fifo_cap       out  constant capacity [ADDR_WIDTH+1]
// -----------------------------------------------------------------------------
module srl_fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   used_q;
  logic [ADDR_WIDTH:0]   used_next;
  logic                  full_n_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  push;
  logic                  pop;
  // srl_pop: an entry leaves the SRL this cycle (to the consumer directly, or
  // into the output register when that stage is built).
  logic                  srl_pop;

  assign push      = if_write & if_write_ce & full_n_q;
  assign if_full_n = full_n_q;

  // Oldest entry sits at used-1; park the address at 0 when empty.
  assign addr = (used_q == '0) ? '0 : ADDR_WIDTH'(used_q - CNT_ONE);

  // SRL storage: new data always enters slot 0, older entries move up.
  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = DEPTH-1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= if_din;
    end
  end

  always_comb begin
    used_next = used_q;
    if (push && !srl_pop)
      used_next = used_q + CNT_ONE;
    else if (!push && srl_pop)
      used_next = used_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      used_q   <= '0;
      full_n_q <= 1'b1;
    end else begin
      used_q   <= used_next;
      full_n_q <= (used_next != CNT_DEPTH);
    end
  end

`ifdef SRL_FIFO_OUT_REG_EN
  logic                  ovalid_q;
  logic [DATA_WIDTH-1:0] dout_q;

  assign pop = if_read & if_read_ce & ovalid_q;
  // Refill the output register whenever it is empty or being drained and
  // the SRL has something to give.
  assign srl_pop = (!ovalid_q || pop) && (used_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (srl_pop) begin
        ovalid_q <= 1'b1;
        dout_q   <= mem[addr];
      end else if (pop) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign if_dout           = dout_q;
  assign if_empty_n        = ovalid_q;
  assign if_num_data_valid = used_q + {{ADDR_WIDTH{1'b0}}, ovalid_q};
  assign if_fifo_cap       = (ADDR_WIDTH+1)'(DEPTH + 1);
`else
  logic empty_n_q;

  assign pop     = if_read & if_read_ce & empty_n_q;
  assign srl_pop = pop;

  always_ff @(posedge clk) begin
    if (reset) empty_n_q <= 1'b0;
    else       empty_n_q <= (used_next != '0);
  end

  assign if_dout           = mem[addr];
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = used_q;
  assign if_fifo_cap       = CNT_DEPTH;
`endif

endmodule

// File: tb/tb_srl_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_srl_fifo_rd_ctrl
//
// Directed bench for srl_fifo_rd_ctrl (default build, DEPTH=4, 8-bit data).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_srl_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [AW:0]   if_num_data_valid;
  logic [AW:0]   if_fifo_cap;

  srl_fifo_rd_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_write_ce      (if_write_ce),
    .if_write         (if_write),
    .if_din           (if_din),
    .if_full_n        (if_full_n),
    .if_read_ce       (if_read_ce),
    .if_read          (if_read),
    .if_dout          (if_dout),
    .if_empty_n       (if_empty_n),
    .if_num_data_valid(if_num_data_valid),
    .if_fifo_cap      (if_fifo_cap)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard of values expected to leave the FIFO, oldest first
  logic [DW-1:0] exp_q[$];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [DW-1:0] din, input logic rd);
    if_write_ce = 1'b1;
    if_read_ce  = 1'b1;
    if_write    = wr;
    if_din      = din;
    if_read     = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_pop(input string tag);
    logic [DW-1:0] e;
    e = exp_q.pop_front();
    chk(tag, 32'(if_dout), 32'(e));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_full_n", 32'(if_full_n), 32'd1);
    chk("rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("rst_ndv", 32'(if_num_data_valid), 32'd0);
    chk("fifo_cap", 32'(if_fifo_cap), 32'd4);

    // fill with 1..4 on consecutive cycles
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      exp_q.push_back(DW'(i));
      tick();
      chk("fill_ndv", 32'(if_num_data_valid), 32'(i));
      chk("fill_full_n", 32'(if_full_n), (i == 4) ? 32'd0 : 32'd1);
    end
    idle();
    chk("fill_empty_n", 32'(if_empty_n), 32'd1);

    // drain, checking order
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_pop("drain_dout");
      tick();
      chk("drain_ndv", 32'(if_num_data_valid), 32'(3 - i));
      chk("drain_full_n", 32'(if_full_n), 32'd1);
    end
    idle();
    chk("drain_empty_n", 32'(if_empty_n), 32'd0);

    // push-to-visible latency of one cycle
    drive(1'b1, 8'h0A, 1'b0);
    chk("lat_before", 32'(if_empty_n), 32'd0);
    tick();
    idle();
    chk("lat_empty_n", 32'(if_empty_n), 32'd1);
    chk("lat_dout", 32'(if_dout), 32'h0A);

    // pop 0xA, then hold 0x5 alone
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b1, 8'h05, 1'b0);
    tick();
    chk("one_ndv", 32'(if_num_data_valid), 32'd1);

    // simultaneous push 0x6 / pop at used==1
    drive(1'b1, 8'h06, 1'b1);
    chk("pp_popped", 32'(if_dout), 32'h05);
    tick();
    idle();
    chk("pp_ndv", 32'(if_num_data_valid), 32'd1);
    chk("pp_dout", 32'(if_dout), 32'h06);
    chk("pp_empty_n", 32'(if_empty_n), 32'd1);

    // fill to full behind 0x6
    exp_q.push_back(8'h06);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(8'h11 + i), 1'b0);
      exp_q.push_back(DW'(8'h11 + i));
      tick();
    end
    idle();
    chk("full2_full_n", 32'(if_full_n), 32'd0);

    // push 0x9 while full with a pop: only the pop happens
    drive(1'b1, 8'h09, 1'b1);
    chk_pop("fullpp_dout");
    tick();
    idle();
    chk("fullpp_ndv", 32'(if_num_data_valid), 32'd3);
    chk("fullpp_full_n", 32'(if_full_n), 32'd1);

    // drain the rest; 0x9 must not appear
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk_pop("drain2_dout");
      tick();
    end
    idle();
    chk("drain2_empty_n", 32'(if_empty_n), 32'd0);
    chk("drain2_ndv", 32'(if_num_data_valid), 32'd0);

    // write request without clock enable is ignored
    drive(1'b1, 8'h33, 1'b0);
    if_write_ce = 1'b0;
    tick();
    idle();
    chk("noce_ndv", 32'(if_num_data_valid), 32'd0);
    chk("noce_empty_n", 32'(if_empty_n), 32'd0);

    // read while empty is ignored
    drive(1'b0, '0, 1'b1);
    tick();
    idle();
    chk("rdempty_ndv", 32'(if_num_data_valid), 32'd0);
    chk("rdempty_empty_n", 32'(if_empty_n), 32'd0);
    chk("rdempty_full_n", 32'(if_full_n), 32'd1);

    // reset with three entries mid-stream, push/pop in the reset cycle ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(8'h21 + i), 1'b0);
      tick();
    end
    chk("pre_rst_ndv", 32'(if_num_data_valid), 32'd3);
    drive(1'b1, 8'h44, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("mrst_empty_n", 32'(if_empty_n), 32'd0);
    chk("mrst_full_n", 32'(if_full_n), 32'd1);
    chk("mrst_ndv", 32'(if_num_data_valid), 32'd0);

    drive(1'b1, 8'h07, 1'b0);
    tick();
    idle();
    chk("post_rst_dout", 32'(if_dout), 32'h07);
    chk("post_rst_ndv", 32'(if_num_data_valid), 32'd1);
    chk("post_rst_empty_n", 32'(if_empty_n), 32'd1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
